// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control FSM.
// States, opcodes, ALU operation codes and immediate formats.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps opcode/funct3/funct7 to an ALU operation and flags
// encodings the core does not implement.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [2:0] o_alu_ctrl,
  output logic       o_illegal
);

  logic [2:0] w_alu;
  logic       w_bad;

  always_comb begin
    w_alu = ALU_ADD;
    w_bad = 1'b0;
    unique case (i_opcode)
      OP_R: begin
        if (i_funct7 == F7_BASE) begin
          unique case (i_funct3)
            3'b000:  w_alu = ALU_ADD;
            3'b001:  w_alu = ALU_SLL;
            3'b010:  w_alu = ALU_SLT;
            3'b100:  w_alu = ALU_XOR;
            3'b101:  w_alu = ALU_SRL;
            3'b110:  w_alu = ALU_OR;
            3'b111:  w_alu = ALU_AND;
            default: w_bad = 1'b1;
          endcase
        end else if (i_funct7 == F7_ALT && i_funct3 == 3'b000) begin
          w_alu = ALU_SUB;
        end else begin
          w_bad = 1'b1;
        end
      end
      OP_I: begin
        unique case (i_funct3)
          3'b000: w_alu = ALU_ADD;
          3'b010: w_alu = ALU_SLT;
          3'b100: w_alu = ALU_XOR;
          3'b110: w_alu = ALU_OR;
          3'b111: w_alu = ALU_AND;
          3'b001: begin
            w_alu = ALU_SLL;
            w_bad = (i_funct7 != F7_BASE);
          end
          3'b101: begin
            w_alu = ALU_SRL;
            w_bad = (i_funct7 != F7_BASE);
          end
          default: w_bad = 1'b1;
        endcase
      end
      OP_LW, OP_SW: w_bad = (i_funct3 != F3_WORD);
      OP_BR: begin
        w_alu = ALU_SUB;
        w_bad = (i_funct3[2:1] != 2'b00);
      end
      default: w_bad = 1'b1;
    endcase
  end

  // rejected encodings report a neutral add
  assign o_alu_ctrl = w_bad ? ALU_ADD : w_alu;
  assign o_illegal  = w_bad;

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I-subset control FSM: latches one instruction,
// steps DECODE/EXEC/MEM/WB and issues one-cycle strobes.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        EQ,
  output logic [2:0]  ALUctrl,
  output logic        ALUsrc,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        ResultSrc,
  output logic        PCsrc,
  output logic        PC_en,
  output logic        illegal
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr;

  logic [6:0] w_opc;
  logic [2:0] w_alu;
  logic       w_bad;
  logic       w_is_i;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_br;
  logic       w_active;
  logic       w_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (instr_valid && r_state == IDLE)
        r_instr <= instr;
    end
  end

  assign w_opc   = r_instr[6:0];
  assign w_is_i  = (w_opc == OP_I);
  assign w_is_lw = (w_opc == OP_LW);
  assign w_is_sw = (w_opc == OP_SW);
  assign w_is_br = (w_opc == OP_BR);

  assign w_active = (r_state != IDLE);
  assign w_unused = ^{r_instr[24:15], r_instr[11:7]};

  alu_decoder u_dec (
    .i_opcode   (w_opc),
    .i_funct3   (r_instr[14:12]),
    .i_funct7   (r_instr[31:25]),
    .o_alu_ctrl (w_alu),
    .o_illegal  (w_bad)
  );

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    ResultSrc   = 1'b0;
    PCsrc       = 1'b0;
    PC_en       = 1'b0;
    illegal     = 1'b0;
    ALUctrl     = ALU_ADD;
    ALUsrc      = 1'b0;
    ImmSrc      = IMM_I;

    if (w_active) begin
      ALUctrl = w_alu;
      ALUsrc  = w_is_i | w_is_lw | w_is_sw;
      ImmSrc  = w_is_sw ? IMM_S : (w_is_br ? IMM_B : IMM_I);
    end

    unique case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid)
          w_next = DECODE;
      end
      DECODE: begin
        illegal = w_bad;
        w_next  = w_bad ? IDLE : EXEC;
      end
      EXEC: begin
        if (w_is_br) begin
          // funct3[0] distinguishes bne from beq
          PCsrc  = r_instr[12] ? !EQ : EQ;
          PC_en  = 1'b1;
          w_next = IDLE;
        end else if (w_is_lw || w_is_sw) begin
          w_next = MEM;
        end else begin
          w_next = WB;
        end
      end
      MEM: begin
        if (w_is_sw) begin
          MemWrite = 1'b1;
          PC_en    = 1'b1;
          w_next   = IDLE;
        end else begin
          w_next = WB;
        end
      end
      WB: begin
        RegWrite  = 1'b1;
        PC_en     = 1'b1;
        ResultSrc = w_is_lw;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed plus random instruction sequences for control_fsm,
// checked cycle by cycle against an instruction-level model.
module tb_control_fsm;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        EQ;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic [1:0]  ImmSrc;
  logic        RegWrite;
  logic        MemWrite;
  logic        ResultSrc;
  logic        PCsrc;
  logic        PC_en;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  control_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .EQ          (EQ),
    .ALUctrl     (ALUctrl),
    .ALUsrc      (ALUsrc),
    .ImmSrc      (ImmSrc),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .ResultSrc   (ResultSrc),
    .PCsrc       (PCsrc),
    .PC_en       (PC_en),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 R/I-type, 1 lw, 2 sw, 3 branch
  typedef struct {
    bit       legal;
    bit [2:0] alu;
    bit       src;
    bit [1:0] imm;
    int       lat;
    int       kind;
  } exp_t;

  localparam logic [12:0] M_ALL   = 13'h1FFF;
  localparam logic [12:0] M_NORDY = 13'h0FFF;
  localparam logic [12:0] M_ILL   = 13'h103F;
  localparam logic [12:0] V_IDLE  = 13'h1000;

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   fmap[8];
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    // funct3 -> ALU op for the base arithmetic group; -1 = none
    fmap = '{0, 6, 4, -1, 5, 7, 3, 2};
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    e = '{legal: 0, alu: 0, src: 0, imm: 0, lat: 1, kind: 0};
    if (op == 7'h33) begin
      if (f7 == 7'h00 && fmap[f3] >= 0) begin
        e.legal = 1;
        e.alu = 3'(fmap[f3]);
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        e.legal = 1;
        e.alu = 3'd1;
      end
      e.lat = 3;
    end else if (op == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5)
        e.legal = (f7 == 7'h00);
      else
        e.legal = (fmap[f3] >= 0);
      if (e.legal) e.alu = 3'(fmap[f3]);
      e.src = 1;
      e.lat = 3;
    end else if (op == 7'h03) begin
      e.legal = (f3 == 3'd2);
      e.src = 1;
      e.lat = 4;
      e.kind = 1;
    end else if (op == 7'h23) begin
      e.legal = (f3 == 3'd2);
      e.src = 1;
      e.imm = 2'b01;
      e.lat = 3;
      e.kind = 2;
    end else if (op == 7'h63) begin
      e.legal = (f3 < 3'd2);
      e.alu = 3'd1;
      e.imm = 2'b10;
      e.lat = 2;
      e.kind = 3;
    end
    if (!e.legal) e.lat = 1;
    return e;
  endfunction

  function automatic logic [12:0] outs();
    return {instr_ready, ALUctrl, ALUsrc, ImmSrc,
            RegWrite, MemWrite, ResultSrc, PCsrc, PC_en, illegal};
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs,
                     input logic [12:0] exp, input logic [12:0] msk);
    n_vec++;
    assert ((obs & msk) === (exp & msk)) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag,
             obs & msk, exp & msk);
    end
  endtask

  task automatic run(input logic [31:0] w, input int eqmode,
                     input string tag);
    exp_t e;
    logic [12:0] x;
    bit last;
    e = model(w);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = w;
    EQ = 1'($urandom);
    #1 chk({tag, "/idle"}, outs(), V_IDLE, M_ALL);
    for (int c = 1; c <= e.lat; c++) begin
      @(negedge clk);
      instr_valid = 1'($urandom);
      instr = $urandom;
      EQ = (eqmode < 0) ? 1'($urandom) : 1'(eqmode);
      #1;
      last = (c == e.lat);
      x = '0;
      x[11:9] = e.alu;
      x[8]    = e.src;
      x[7:6]  = e.imm;
      x[5] = e.legal && last && (e.kind <= 1);
      x[4] = e.legal && last && (e.kind == 2);
      x[3] = e.legal && last && (e.kind == 1);
      x[2] = e.legal && last && (e.kind == 3) && (w[12] ? !EQ : EQ);
      x[1] = e.legal && last;
      x[0] = !e.legal && (c == 1);
      chk($sformatf("%s/c%0d", tag, c), outs(), x,
          e.legal ? M_ALL : M_ILL);
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    logic [6:0]  ops[5];
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) w[6:0] = ops[k % 5];
    k = $urandom_range(0, 3);
    if (k == 0) w[31:25] = 7'h00;
    if (k == 1) w[31:25] = 7'h20;
    if ((w[6:0] == 7'h03 || w[6:0] == 7'h23) && $urandom_range(0, 2) != 0)
      w[14:12] = 3'd2;
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    EQ = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 32'h002081B3;
    #1 chk("reset_hold", outs(), V_IDLE, M_ALL);
    @(negedge clk);
    #1 chk("reset_valid_ignored", outs(), V_IDLE, M_ALL);
    instr_valid = 1'b0;
    rst = 1'b0;

    run(32'h002081B3, -1, "add");
    run(32'h402081B3, -1, "sub");
    run(32'h00208463, 1, "beq_eq1");
    run(32'h00208463, 0, "beq_eq0");
    run(32'h00209463, 1, "bne_eq1");
    run(32'h0040A283, -1, "lw");
    run(32'h0020A223, -1, "sw");
    run(32'hFFFFFFFF, -1, "ones");
    run(32'h4020D1B3, -1, "sra");
    run(32'h4010D093, -1, "srai");
    run(32'h0020B1B3, -1, "sltu");

    // abort a load in its MEM cycle with an asynchronous reset
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 32'h0040A283;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("lw_mem", outs(), 13'h0100, M_ALL);
    #2 rst = 1'b1;
    #1 chk("rst_async", outs(), 13'h0000, M_NORDY);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("post_rst%0d", i), outs(), V_IDLE, M_ALL);
    end
    run(32'h002081B3, -1, "add_after_rst");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        instr_valid = 1'b0;
        instr = $urandom;
        #1 chk("gap", outs(), V_IDLE, M_ALL);
      end
      run(rnd_instr(), -1, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    instr_valid = 1'b0;
    #1 chk("final_idle", outs(), V_IDLE, M_ALL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
